// File: rtl/neurochip_pkg.sv
// Shared definitions for the neurochip configuration chain controller.
// Holds the sequencer state encoding, mode codes and the default chain length.
package neurochip_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READBACK,
        FIN
    } state_t;

    localparam logic MODE_LOAD     = 1'b0;
    localparam logic MODE_READBACK = 1'b1;

    localparam int BS_BITS_DEFAULT = 256;

endpackage

// File: rtl/bs_config_ctrl_if.sv
// Host-side control and byte streams of the bitstream sequencer.
// The host is the master; the controller is the slave.
interface bs_config_ctrl_if;

    logic       start;
    logic       mode;
    logic       abort;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] rd_byte;
    logic       rd_valid;
    logic       rd_ready;
    logic       busy;
    logic       done;

    modport master (
        output start, mode, abort, byte_in, byte_valid, rd_ready,
        input  byte_ready, rd_byte, rd_valid, busy, done
    );

    modport slave (
        input  start, mode, abort, byte_in, byte_valid, rd_ready,
        output byte_ready, rd_byte, rd_valid, busy, done
    );

endinterface

// File: rtl/bs_serdes_byte.sv
// Byte-wide shift register shared by load (serialise, MSB first) and
// readback (deserialise, first bit ends up in the MSB).
module bs_serdes_byte (
    input  logic       clk,
    input  logic       clr,
    input  logic       rd_dir,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       shift,
    input  logic       cap_bit,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       bit_out,
    output logic       full,
    output logic       last
);

    logic [7:0] sr;
    logic [2:0] idx;
    logic       full_q;

    // A load in the same cycle as the final shift replaces the byte seamlessly.
    always_ff @(posedge clk) begin
        if (clr) begin
            sr     <= 8'h00;
            idx    <= 3'd0;
            full_q <= 1'b0;
        end else if (load) begin
            sr     <= din;
            idx    <= 3'd0;
            full_q <= 1'b1;
        end else begin
            if (shift) begin
                sr  <= {sr[6:0], rd_dir ? cap_bit : 1'b0};
                idx <= idx + 3'd1;
            end
            if (rd_dir) begin
                if (shift && last)
                    full_q <= 1'b1;
                else if (pop)
                    full_q <= 1'b0;
            end else if (shift && last) begin
                full_q <= 1'b0;
            end
        end
    end

    assign dout    = sr;
    assign bit_out = sr[7];
    assign full    = full_q;
    assign last    = (idx == 3'd7);

endmodule

// File: rtl/bs_config_ctrl.sv
// Sequencer for the configuration bitstream chain: serialises host bytes into
// the chain and reads it back non-destructively by recirculating bs_out.
module bs_config_ctrl
    import neurochip_pkg::*;
#(
    parameter  int BS_BITS = BS_BITS_DEFAULT,
    localparam int CNT_W   = $clog2(BS_BITS + 1)
) (
    input  logic           clk,
    input  logic           reset,
    bs_config_ctrl_if.slave host,
    output logic           config_en,
    output logic           bs_in,
    input  logic           bs_out
);

    localparam int NBYTES = BS_BITS / 8;
    localparam int BC_W   = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(BS_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BS_BITS - 1);
    localparam logic [BC_W-1:0]  NB_END   = BC_W'(NBYTES);

    state_t           st, st_nxt;
    logic [CNT_W-1:0] cnt;
    logic [BC_W-1:0]  nbytes;

    logic       in_load, in_rd, entry, sd_clr;
    logic       accept, shift_ld, shift_rd, pop;
    logic [7:0] sd_dout;
    logic       sd_bit, sd_full, sd_last;

    assign in_load = (st == LOAD);
    assign in_rd   = (st == READBACK);
    assign entry   = (st == IDLE) && host.start && !host.abort;
    assign sd_clr  = reset || host.abort || entry;

    assign host.byte_ready = in_load && (!sd_full || sd_last) && (nbytes < NB_END);
    assign accept          = host.byte_valid && host.byte_ready;

    // Readback stalls only while an unconsumed byte would be overwritten.
    assign shift_ld  = in_load && sd_full;
    assign shift_rd  = in_rd && (cnt < CNT_END) && !(sd_full && !host.rd_ready);
    assign config_en = shift_ld || shift_rd;
    assign bs_in     = shift_ld ? sd_bit : (shift_rd ? bs_out : 1'b0);

    assign host.rd_valid = in_rd && sd_full;
    assign host.rd_byte  = host.rd_valid ? sd_dout : 8'h00;
    assign pop           = host.rd_valid && host.rd_ready;

    assign host.busy = in_load || in_rd;
    assign host.done = (st == FIN);

    bs_serdes_byte u_serdes (
        .clk     (clk),
        .clr     (sd_clr),
        .rd_dir  (in_rd),
        .load    (accept),
        .din     (host.byte_in),
        .shift   (config_en),
        .cap_bit (bs_out),
        .pop     (pop),
        .dout    (sd_dout),
        .bit_out (sd_bit),
        .full    (sd_full),
        .last    (sd_last)
    );

    always_ff @(posedge clk) begin
        if (reset)
            st <= IDLE;
        else
            st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:     if (host.start)
                          st_nxt = (host.mode == MODE_READBACK) ? READBACK : LOAD;
            LOAD:     if (config_en && cnt == CNT_LAST) st_nxt = FIN;
            READBACK: if (cnt == CNT_END && pop)       st_nxt = FIN;
            FIN:      st_nxt = IDLE;
            default:  st_nxt = IDLE;
        endcase
        if (host.abort)
            st_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset || entry) begin
            cnt    <= '0;
            nbytes <= '0;
        end else begin
            if (config_en)
                cnt <= cnt + 1'b1;
            if (accept)
                nbytes <= nbytes + 1'b1;
        end
    end

endmodule

// File: tb/tb_bs_config_ctrl.sv
// Directed bench for bs_config_ctrl with a behavioural model of the serial chain.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_bs_config_ctrl;
    import neurochip_pkg::*;

    localparam int BS = 256;
    localparam int NB = BS / 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bs_config_ctrl_if hif ();
    logic config_en, bs_in, bs_out;

    bs_config_ctrl #(.BS_BITS(BS)) dut (
        .clk       (clk),
        .reset     (reset),
        .host      (hif.slave),
        .config_en (config_en),
        .bs_in     (bs_in),
        .bs_out    (bs_out)
    );

    // Chain model: bit BS-1 is the far end driven onto bs_out.
    logic [BS-1:0] chain;
    assign bs_out = chain[BS-1];
    always @(posedge clk) if (config_en) chain <= {chain[BS-2:0], bs_in};

    int chk  = 0;
    int pass = 0;
    logic [BS-1:0] exp_inc, exp_a5;
    logic [7:0] rd_q[$];

    task automatic idle_inputs();
        hif.start = 0; hif.mode = 0; hif.abort = 0;
        hif.byte_in = 8'h00; hif.byte_valid = 0; hif.rd_ready = 0;
    endtask

    task automatic start_op(input logic m);
        @(negedge clk);
        idle_inputs();
        hif.start = 1'b1;
        hif.mode  = m;
    endtask

    task automatic run_load(input int toggle, input bit use_a5, input int abort_after,
                            input int inj_at, output int en_total, output int en_err,
                            output int stalls, output int done_cnt, output bit tmo,
                            output logic [3:0] post);
        int pending = 0;
        int bi = 0;
        int c = 0;
        bit fin = 0;
        en_total = 0; en_err = 0; stalls = 0; done_cnt = 0;
        start_op(MODE_LOAD);
        while (!fin && c < 3000) begin
            @(negedge clk);
            hif.start      = (c == inj_at);
            hif.mode       = (c == inj_at);
            hif.abort      = (abort_after >= 0) && (en_total == abort_after);
            hif.byte_valid = (bi < NB) && (toggle == 0 || (c % 6) == 0);
            hif.byte_in    = use_a5 ? 8'hA5 : 8'(bi);
            #1;
            if (config_en !== (pending > 0)) en_err++;
            if (hif.busy && !config_en) stalls++;
            if (hif.done) done_cnt++;
            if (config_en) en_total++;
            pending = pending - (config_en ? 1 : 0);
            if (hif.byte_valid && hif.byte_ready) begin
                pending += 8;
                bi++;
            end
            if (hif.abort || hif.done) fin = 1;
            c++;
        end
        tmo = !fin;
        @(negedge clk);
        idle_inputs();
        #1;
        post = {hif.busy, hif.done, hif.byte_ready, config_en};
        repeat (5) begin
            @(negedge clk);
            #1;
            if (hif.done) done_cnt++;
        end
    endtask

    task automatic run_rd(input int stall_len, input int reset_at, output int en_total,
                          output int stall_err, output int done_cnt, output bit tmo,
                          output logic [5:0] post, output logic [7:0] post_byte);
        int c = 0;
        int srem = 0;
        bit first = 0;
        bit fin = 0;
        bit in_stall;
        logic [7:0] held = 8'h00;
        en_total = 0; stall_err = 0; done_cnt = 0;
        rd_q.delete();
        start_op(MODE_READBACK);
        while (!fin && c < 3000) begin
            @(negedge clk);
            hif.start = 0;
            hif.mode  = 0;
            if (hif.rd_valid && !first) begin
                first = 1;
                srem  = stall_len;
                held  = hif.rd_byte;
            end
            in_stall = (srem > 0);
            hif.rd_ready = !in_stall;
            if (in_stall) srem--;
            reset = (reset_at >= 0) && (en_total == reset_at);
            #1;
            if (in_stall && (config_en || !hif.rd_valid || hif.rd_byte !== held)) stall_err++;
            if (config_en) en_total++;
            if (hif.rd_valid && hif.rd_ready) rd_q.push_back(hif.rd_byte);
            if (hif.done) begin
                done_cnt++;
                fin = 1;
            end
            if (reset) fin = 1;
            c++;
        end
        tmo = !fin;
        @(negedge clk);
        reset = 0;
        idle_inputs();
        #1;
        post = {hif.busy, hif.done, hif.byte_ready, hif.rd_valid, config_en, bs_in};
        post_byte = hif.rd_byte;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        repeat (3) @(negedge clk);
        reset = 0;
        #1;
        chk++; if (hif.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", hif.busy); else pass++;
        chk++; if (hif.done !== 1'b0) $display("FAIL reset_done: got %b want 0", hif.done); else pass++;
        chk++; if (hif.byte_ready !== 1'b0) $display("FAIL reset_byte_ready: got %b want 0", hif.byte_ready); else pass++;
        chk++; if (hif.rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", hif.rd_valid); else pass++;
        chk++; if (hif.rd_byte !== 8'h00) $display("FAIL reset_rd_byte: got %h want 00", hif.rd_byte); else pass++;
        chk++; if ({config_en, bs_in} !== 2'b00) $display("FAIL reset_chain_pins: got %b want 00", {config_en, bs_in}); else pass++;
    endtask

    task automatic test_load_basic();
        int en_total, en_err, stalls, done_cnt;
        bit tmo;
        logic [3:0] post;
        run_load(0, 0, -1, -1, en_total, en_err, stalls, done_cnt, tmo, post);
        chk++; if (tmo !== 1'b0) $display("FAIL load_timeout: got %b want 0", tmo); else pass++;
        chk++; if (en_total != 256) $display("FAIL load_en_total: got %0d want 256", en_total); else pass++;
        chk++; if (stalls != 1) $display("FAIL load_stalls: got %0d want 1", stalls); else pass++;
        chk++; if (en_err != 0) $display("FAIL load_en_pattern: got %0d bad cycles want 0", en_err); else pass++;
        chk++; if (chain !== exp_inc) $display("FAIL load_chain: got %h want %h", chain, exp_inc); else pass++;
        chk++; if (done_cnt != 1) $display("FAIL load_done_count: got %0d want 1", done_cnt); else pass++;
        chk++; if (post !== 4'b0000) $display("FAIL load_post_idle: got %b want 0000", post); else pass++;
    endtask

    task automatic test_readback();
        int en_total, stall_err, done_cnt, bad;
        bit tmo;
        logic [5:0] post;
        logic [7:0] pb;
        run_rd(0, -1, en_total, stall_err, done_cnt, tmo, post, pb);
        bad = 0;
        foreach (rd_q[i]) if (rd_q[i] !== 8'(i)) bad++;
        chk++; if (tmo !== 1'b0) $display("FAIL rd_timeout: got %b want 0", tmo); else pass++;
        chk++; if (rd_q.size() != NB) $display("FAIL rd_count: got %0d want %0d", rd_q.size(), NB); else pass++;
        chk++; if (bad != 0) $display("FAIL rd_bytes: got %0d wrong bytes want 0", bad); else pass++;
        chk++; if (en_total != 256) $display("FAIL rd_en_total: got %0d want 256", en_total); else pass++;
        chk++; if (chain !== exp_inc) $display("FAIL rd_chain_kept: got %h want %h", chain, exp_inc); else pass++;
        chk++; if (done_cnt != 1) $display("FAIL rd_done_count: got %0d want 1", done_cnt); else pass++;
        chk++; if (post !== 6'b000000) $display("FAIL rd_post_idle: got %b want 000000", post); else pass++;
    endtask

    task automatic test_abort();
        int en_total, en_err, stalls, done_cnt;
        bit tmo;
        logic [3:0] post;
        run_load(0, 0, 100, -1, en_total, en_err, stalls, done_cnt, tmo, post);
        chk++; if (tmo !== 1'b0) $display("FAIL abort_timeout: got %b want 0", tmo); else pass++;
        chk++; if (post !== 4'b0000) $display("FAIL abort_post_idle: got %b want 0000", post); else pass++;
        chk++; if (done_cnt != 0) $display("FAIL abort_no_done: got %0d want 0", done_cnt); else pass++;
        run_load(0, 1, -1, -1, en_total, en_err, stalls, done_cnt, tmo, post);
        chk++; if (en_total != 256) $display("FAIL abort_reload_en_total: got %0d want 256", en_total); else pass++;
        chk++; if (chain !== exp_a5) $display("FAIL abort_reload_chain: got %h want %h", chain, exp_a5); else pass++;
        chk++; if (done_cnt != 1) $display("FAIL abort_reload_done: got %0d want 1", done_cnt); else pass++;
    endtask

    task automatic test_load_toggle();
        int en_total, en_err, stalls, done_cnt;
        bit tmo;
        logic [3:0] post;
        run_load(1, 0, -1, -1, en_total, en_err, stalls, done_cnt, tmo, post);
        chk++; if (tmo !== 1'b0) $display("FAIL toggle_timeout: got %b want 0", tmo); else pass++;
        chk++; if (en_err != 0) $display("FAIL toggle_en_pattern: got %0d bad cycles want 0", en_err); else pass++;
        chk++; if (stalls != 125) $display("FAIL toggle_stalls: got %0d want 125", stalls); else pass++;
        chk++; if (en_total != 256) $display("FAIL toggle_en_total: got %0d want 256", en_total); else pass++;
        chk++; if (chain !== exp_inc) $display("FAIL toggle_chain: got %h want %h", chain, exp_inc); else pass++;
        chk++; if (done_cnt != 1) $display("FAIL toggle_done: got %0d want 1", done_cnt); else pass++;
    endtask

    task automatic test_readback_stall();
        int en_total, stall_err, done_cnt, bad;
        bit tmo;
        logic [5:0] post;
        logic [7:0] pb;
        run_rd(20, -1, en_total, stall_err, done_cnt, tmo, post, pb);
        bad = 0;
        foreach (rd_q[i]) if (rd_q[i] !== 8'(i)) bad++;
        chk++; if (tmo !== 1'b0) $display("FAIL rdstall_timeout: got %b want 0", tmo); else pass++;
        chk++; if (stall_err != 0) $display("FAIL rdstall_hold: got %0d bad cycles want 0", stall_err); else pass++;
        chk++; if (rd_q.size() != NB || bad != 0) $display("FAIL rdstall_bytes: got %0d bytes %0d wrong want %0d bytes 0 wrong", rd_q.size(), bad, NB); else pass++;
        chk++; if (en_total != 256) $display("FAIL rdstall_en_total: got %0d want 256", en_total); else pass++;
        chk++; if (chain !== exp_inc) $display("FAIL rdstall_chain_kept: got %h want %h", chain, exp_inc); else pass++;
    endtask

    task automatic test_start_ignored();
        int en_total, en_err, stalls, done_cnt;
        bit tmo;
        logic [3:0] post;
        run_load(0, 1, -1, 50, en_total, en_err, stalls, done_cnt, tmo, post);
        chk++; if (en_total != 256 || en_err != 0) $display("FAIL start_ign_en: got total %0d err %0d want 256 0", en_total, en_err); else pass++;
        chk++; if (chain !== exp_a5) $display("FAIL start_ign_chain: got %h want %h", chain, exp_a5); else pass++;
        chk++; if (done_cnt != 1 || tmo) $display("FAIL start_ign_done: got %0d tmo %b want 1 0", done_cnt, tmo); else pass++;
    endtask

    task automatic test_reset_mid_rd();
        int en_total, stall_err, done_cnt;
        bit tmo;
        logic [5:0] post;
        logic [7:0] pb;
        run_rd(0, 60, en_total, stall_err, done_cnt, tmo, post, pb);
        chk++; if (post !== 6'b000000) $display("FAIL rst_mid_outputs: got %b want 000000", post); else pass++;
        chk++; if (pb !== 8'h00) $display("FAIL rst_mid_rd_byte: got %h want 00", pb); else pass++;
        chk++; if (done_cnt != 0) $display("FAIL rst_mid_no_done: got %0d want 0", done_cnt); else pass++;
        @(negedge clk);
        hif.start = 1; hif.mode = MODE_LOAD;
        @(negedge clk);
        hif.start = 0;
        #1;
        chk++; if ({hif.busy, hif.byte_ready} !== 2'b11) $display("FAIL rst_mid_restart: got %b want 11", {hif.busy, hif.byte_ready}); else pass++;
        @(negedge clk);
        hif.abort = 1;
        @(negedge clk);
        hif.abort = 0;
    endtask

    initial begin
        exp_inc = '0;
        exp_a5  = '0;
        for (int i = 0; i < NB; i++) begin
            exp_inc = {exp_inc[BS-9:0], 8'(i)};
            exp_a5  = {exp_a5[BS-9:0], 8'hA5};
        end
        test_reset();
        test_load_basic();
        test_readback();
        test_abort();
        test_load_toggle();
        test_readback_stall();
        test_start_ignored();
        test_reset_mid_rd();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
